// File: rtl/hazard_ctrl.sv
//----------------------------------------------------------------------------
// Module      : hazard_ctrl
// Description : Hazard controller for a 5-stage integer pipeline. It tracks
//               the E/M/W stages and produces forwarding, stall, flush and
//               freeze controls, plus saturating event counters.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             freeze,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             byp_a_d,
    output logic             byp_b_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [1:0] c_FWD_RF = 2'b00;
    localparam logic [1:0] c_FWD_W  = 2'b01;
    localparam logic [1:0] c_FWD_M  = 2'b10;

    // Shadow scoreboard of the E, M and W stages.
    logic            r_e_valid;
    logic [RA_W-1:0] r_e_rs1;
    logic [RA_W-1:0] r_e_rs2;
    logic [RA_W-1:0] r_e_rd;
    logic            r_e_regwrite;
    logic            r_e_is_load;

    logic            r_m_valid;
    logic [RA_W-1:0] r_m_rd;
    logic            r_m_regwrite;
    logic            r_m_is_load;

    logic            r_w_valid;
    logic [RA_W-1:0] r_w_rd;
    logic            r_w_regwrite;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic w_lu;
    logic w_stall_f;
    logic w_stall_d;
    logic w_flush_d;
    logic w_flush_e;
    logic w_freeze;
    logic w_inc_stall;
    logic w_inc_flush;
    logic w_inc_freeze;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic w_byp_a;
    logic w_byp_b;

    // x0 is hard-wired to zero, so a slot targeting it never produces a value.
    function automatic logic slot_writes(
        input logic            v,
        input logic            rw,
        input logic [RA_W-1:0] rd,
        input logic [RA_W-1:0] r
    );
        return v & rw & (rd != '0) & (rd == r);
    endfunction

    assign w_lu = id_valid & r_e_is_load &
                  ((id_use_rs1 & slot_writes(r_e_valid, r_e_regwrite, r_e_rd, id_rs1)) |
                   (id_use_rs2 & slot_writes(r_e_valid, r_e_regwrite, r_e_rd, id_rs2)));

    // Priority: memory wait, then taken branch, then load-use.
    always_comb begin
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_freeze     = 1'b0;
        w_inc_stall  = 1'b0;
        w_inc_flush  = 1'b0;
        w_inc_freeze = 1'b0;
        if (!rst) begin
            w_freeze = 1'b0;
        end else if (mem_wait) begin
            w_freeze     = 1'b1;
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_inc_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            w_flush_d   = 1'b1;
            w_flush_e   = 1'b1;
            w_inc_flush = 1'b1;
        end else if (w_lu) begin
            w_stall_f   = 1'b1;
            w_stall_d   = 1'b1;
            w_flush_e   = 1'b1;
            w_inc_stall = 1'b1;
        end
    end

    // M has priority over W; a load in M has no data yet and is skipped.
    always_comb begin
        w_fwd_a = c_FWD_RF;
        w_fwd_b = c_FWD_RF;
        if (rst && r_e_valid) begin
            if (slot_writes(r_m_valid, r_m_regwrite, r_m_rd, r_e_rs1) && !r_m_is_load)
                w_fwd_a = c_FWD_M;
            else if (slot_writes(r_w_valid, r_w_regwrite, r_w_rd, r_e_rs1))
                w_fwd_a = c_FWD_W;

            if (slot_writes(r_m_valid, r_m_regwrite, r_m_rd, r_e_rs2) && !r_m_is_load)
                w_fwd_b = c_FWD_M;
            else if (slot_writes(r_w_valid, r_w_regwrite, r_w_rd, r_e_rs2))
                w_fwd_b = c_FWD_W;
        end
    end

    assign w_byp_a = rst & id_use_rs1 & slot_writes(r_w_valid, r_w_regwrite, r_w_rd, id_rs1);
    assign w_byp_b = rst & id_use_rs2 & slot_writes(r_w_valid, r_w_regwrite, r_w_rd, id_rs2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_valid    <= 1'b0;
            r_e_rs1      <= '0;
            r_e_rs2      <= '0;
            r_e_rd       <= '0;
            r_e_regwrite <= 1'b0;
            r_e_is_load  <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_rd       <= '0;
            r_m_regwrite <= 1'b0;
            r_m_is_load  <= 1'b0;
            r_w_valid    <= 1'b0;
            r_w_rd       <= '0;
            r_w_regwrite <= 1'b0;
        end else if (!mem_wait) begin
            r_w_valid    <= r_m_valid;
            r_w_rd       <= r_m_rd;
            r_w_regwrite <= r_m_regwrite;

            r_m_valid    <= r_e_valid;
            r_m_rd       <= r_e_rd;
            r_m_regwrite <= r_e_regwrite;
            r_m_is_load  <= r_e_is_load;

            r_e_valid    <= id_valid & ~w_flush_e;
            r_e_rs1      <= id_rs1;
            r_e_rs2      <= id_rs2;
            r_e_rd       <= id_rd;
            r_e_regwrite <= id_regwrite;
            r_e_is_load  <= id_is_load;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_inc_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_inc_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_inc_freeze && (r_freeze_cnt != '1))
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign stall_f    = w_stall_f;
    assign stall_d    = w_stall_d;
    assign flush_d    = w_flush_d;
    assign flush_e    = w_flush_e;
    assign freeze     = w_freeze;
    assign fwd_a_e    = w_fwd_a;
    assign fwd_b_e    = w_fwd_b;
    assign byp_a_d    = w_byp_a;
    assign byp_b_d    = w_byp_b;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//----------------------------------------------------------------------------
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (CNT_W = 4).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_regwrite;
    logic       id_is_load;
    logic       ex_branch_taken;
    logic       mem_wait;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       freeze;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       byp_a_d;
    logic       byp_b_d;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
    logic [3:0] freeze_cnt;

    // {stall_f, stall_d, flush_d, flush_e, freeze}
    logic [4:0] ctl;
    assign ctl = {stall_f, stall_d, flush_d, flush_e, freeze};

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(.CNT_W(4), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .flush_e(flush_e), .freeze(freeze),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .byp_a_d(byp_a_d), .byp_b_d(byp_b_d),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_is_load = ld;
    endtask

    task automatic idle_d();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_d();
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        mem_wait = 1'b1;
        ex_branch_taken = 1'b1;
        set_d(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b0;
        #2;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL reset_ctl: got %b want 00000", ctl); end
        n_cmp++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a_e, fwd_b_e}); end
        n_cmp++; if ({byp_a_d, byp_b_d} !== 2'b00) begin n_err++; $display("FAIL reset_byp: got %b want 00", {byp_a_d, byp_b_d}); end
        n_cmp++; if ({stall_cnt, flush_cnt, freeze_cnt} !== 12'h000) begin n_err++; $display("FAIL reset_cnt: got %h want 000", {stall_cnt, flush_cnt, freeze_cnt}); end
        do_reset();
    endtask

    task automatic test_raw_chain();
        do_reset();
        set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5,x1,x2
        tick();
        set_d(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);   // sub x6,x5,x7
        #2;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL raw_no_stall: got %b want 00000", ctl); end
        tick();
        set_d(1'b1, 5'd5, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);   // and x9,x5,x1
        #2;
        n_cmp++; if (fwd_a_e !== 2'b10) begin n_err++; $display("FAIL raw_fwd_a_m: got %b want 10", fwd_a_e); end
        n_cmp++; if (fwd_b_e !== 2'b00) begin n_err++; $display("FAIL raw_fwd_b_m: got %b want 00", fwd_b_e); end
        tick();
        set_d(1'b1, 5'd5, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);  // or x10,x5,x3
        #2;
        n_cmp++; if (fwd_a_e !== 2'b01) begin n_err++; $display("FAIL raw_fwd_a_w: got %b want 01", fwd_a_e); end
        n_cmp++; if (fwd_b_e !== 2'b00) begin n_err++; $display("FAIL raw_fwd_b_w: got %b want 00", fwd_b_e); end
        n_cmp++; if ({byp_a_d, byp_b_d} !== 2'b10) begin n_err++; $display("FAIL raw_byp: got %b want 10", {byp_a_d, byp_b_d}); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x3,0(x2)
        tick();
        set_d(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // add x4,x3,x1
        #2;
        n_cmp++; if (ctl !== 5'b11010) begin n_err++; $display("FAIL lu_stall: got %b want 11010", ctl); end
        tick();
        #2;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL lu_one_cycle: got %b want 00000", ctl); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
        tick();
        idle_d();
        #2;
        n_cmp++; if ({fwd_a_e, fwd_b_e} !== 4'b0100) begin n_err++; $display("FAIL lu_fwd_w: got %b want 0100", {fwd_a_e, fwd_b_e}); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt_hold: got %0d want 1", stall_cnt); end
        tick();
    endtask

    task automatic test_x0_guard();
        do_reset();
        set_d(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x0,0(x1)
        tick();
        set_d(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);   // add x0,x0,x0
        #2;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL x0_no_stall: got %b want 00000", ctl); end
        tick();
        set_d(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);   // add x2,x0,x0
        tick();
        set_d(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        n_cmp++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin n_err++; $display("FAIL x0_fwd: got %b want 0000", {fwd_a_e, fwd_b_e}); end
        n_cmp++; if ({byp_a_d, byp_b_d} !== 2'b00) begin n_err++; $display("FAIL x0_byp: got %b want 00", {byp_a_d, byp_b_d}); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL x0_stall_cnt: got %0d want 0", stall_cnt); end
        tick();
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_d(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x3
        tick();
        set_d(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // add x4,x3,x1
        ex_branch_taken = 1'b1;
        #2;
        n_cmp++; if (ctl !== 5'b00110) begin n_err++; $display("FAIL br_lu_ctl: got %b want 00110", ctl); end
        tick();
        ex_branch_taken = 1'b0;
        idle_d();
        #2;
        n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL br_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL br_after: got %b want 00000", ctl); end
        tick();
    endtask

    task automatic test_mem_wait_branch();
        do_reset();
        set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);   // add x5
        tick();
        set_d(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);   // addi x7,x5
        tick();
        idle_d();
        mem_wait = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (ctl !== 5'b11001) begin n_err++; $display("FAIL mw_ctl[%0d]: got %b want 11001", i, ctl); end
            n_cmp++; if (fwd_a_e !== 2'b10) begin n_err++; $display("FAIL mw_slots_hold[%0d]: got %b want 10", i, fwd_a_e); end
            n_cmp++; if (freeze_cnt !== 4'(i)) begin n_err++; $display("FAIL mw_freeze_cnt[%0d]: got %0d want %0d", i, freeze_cnt, i); end
            tick();
        end
        mem_wait = 1'b0;
        #2;
        n_cmp++; if (ctl !== 5'b00110) begin n_err++; $display("FAIL mw_flush_after: got %b want 00110", ctl); end
        n_cmp++; if ({freeze_cnt, flush_cnt} !== 8'h30) begin n_err++; $display("FAIL mw_cnts: got %h want 30", {freeze_cnt, flush_cnt}); end
        tick();
        ex_branch_taken = 1'b0;
        set_d(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL mw_flush_cnt: got %0d want 1", flush_cnt); end
        n_cmp++; if (fwd_a_e !== 2'b00) begin n_err++; $display("FAIL mw_e_bubble: got %b want 00", fwd_a_e); end
        n_cmp++; if (byp_a_d !== 1'b1) begin n_err++; $display("FAIL mw_byp_w: got %b want 1", byp_a_d); end
        tick();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        set_d(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);   // lw x3,0(x3): stalls every other cycle
        for (int c = 0; c < 41; c++) begin
            tick();
            if (c == 27) begin
                n_cmp++; if (stall_cnt !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d want 14", stall_cnt); end
            end
        end
        #2;
        n_cmp++; if (ctl !== 5'b11010) begin n_err++; $display("FAIL sat_stalling: got %b want 11010", ctl); end
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
        mem_wait = 1'b1;
        #1;
        n_cmp++; if (ctl !== 5'b11001) begin n_err++; $display("FAIL sat_freeze: got %b want 11001", ctl); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL async_rst_ctl: got %b want 00000", ctl); end
        n_cmp++; if ({stall_cnt, flush_cnt, freeze_cnt} !== 12'h000) begin n_err++; $display("FAIL async_rst_cnt: got %h want 000", {stall_cnt, flush_cnt, freeze_cnt}); end
        tick();
        mem_wait = 1'b0;
        rst = 1'b1;
        #2;
        n_cmp++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL rst_no_pending: got %b want 00000", ctl); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        idle_d();
        test_reset();
        test_raw_chain();
        test_load_use();
        test_x0_guard();
        test_branch_lu();
        test_mem_wait_branch();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage integer core (F, D, E, M, W).
- Keeps its own shadow scoreboard of the register indices and write-control bits in the E, M and W stages.
- From the scoreboard it generates forwarding selects, load-use stalls, branch flushes and global freezes for external memory waits.
- Sits beside the decode stage and drives the stall/flush enables of the F/D and D/E pipeline registers.
- Also keeps saturating performance counters for stall and flush events.

Parameters:
- CNT_W, 16: width of each performance counter.
- RA_W, 5: register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  D stage holds a real instruction.
- id_rs1  in  RA_W  D source register 1 (Instr[19:15]).
- id_rs2  in  RA_W  D source register 2 (Instr[24:20]).
- id_rd  in  RA_W  D destination register (Instr[11:7]).
- id_use_rs1  in  1  D instruction reads rs1.
- id_use_rs2  in  1  D instruction reads rs2.
- id_regwrite  in  1  D instruction writes rd.
- id_is_load  in  1  D instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in E.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- stall_f  out  1  hold the PC.
- stall_d  out  1  hold the F/D register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  load a bubble into the D/E register.
- freeze  out  1  hold the E/M and M/W registers.
- fwd_a_e  out  2  E operand A select: 00 = RF, 01 = W result, 10 = M ALU result.
- fwd_b_e  out  2  E operand B select, same encoding.
- byp_a_d  out  1  D operand A takes ResultW (same-cycle write-through).
- byp_b_d  out  1  D operand B takes ResultW.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of branch flush events.
- freeze_cnt  out  CNT_W  count of mem_wait freeze cycles.

Behaviour:
- Scoreboard slots:
  - E: valid, rs1, rs2, rd, regwrite, is_load.
  - M: valid, rd, regwrite, is_load.
  - W: valid, rd, regwrite.
- A slot "writes r" when valid & regwrite & rd != 0 & rd == r. Register x0 never matches.
- Reset (rst low, asynchronous): all slots invalid, all counters 0. All outputs 0, fwd selects 00.
- Load-use hazard (lu):
  - Condition: id_valid & E.valid & E.is_load & E.regwrite & E.rd != 0 & ((id_use_rs1 & id_rs1 == E.rd) | (id_use_rs2 & id_rs2 == E.rd)).
- Output priority (combinational, from current inputs and slots):
  1. mem_wait = 1:
     - freeze = stall_f = stall_d = 1; flush_d = flush_e = 0.
     - Slots hold. ex_branch_taken and lu are ignored this cycle; E holds, so they re-evaluate next cycle.
  2. ex_branch_taken = 1:
     - flush_d = flush_e = 1; stall_f = stall_d = 0. A coincident lu is suppressed.
  3. lu = 1:
     - stall_f = stall_d = 1, flush_e = 1.
  4. Otherwise all of these are 0.
- Slot update at posedge clk when mem_wait = 0:
  - W <= M; M <= E.
  - E <= bubble (valid = 0) if flush_e.
  - Otherwise E <= D fields with valid = id_valid.
- Forwarding (E stage):
  - fwd_a_e = 10 if M writes E.rs1 and !M.is_load.
  - Else 01 if W writes E.rs1.
  - Else 00.
  - fwd_b_e uses E.rs2 the same way. M has priority over W.
  - Both are 00 when E is invalid.
- D bypass: byp_a_d = W writes id_rs1 & id_use_rs1. byp_b_d is the same with rs2. Valid even while stalled.
- Counters:
  - Increment on cycles where lu is the winning condition, ex_branch_taken is the winning condition, or mem_wait = 1, respectively.
  - Each saturates at all-ones and never wraps.
- A reset asserted mid-stall or mid-freeze takes effect immediately. No pending stall survives reset.

Test Plan:
- RAW chain: E slot "add x5" (rd = 5, regwrite), D "sub x6, x5, x7":
  - Next cycle fwd_a_e = 10.
  - One cycle later, with a new D instruction, the W-resident x5 is consumed by the following instr: fwd = 01.
- Load-use: E "lw x3", D "add x4, x3, x1" -> stall_f = stall_d = flush_e = 1 for exactly 1 cycle, stall_cnt = 1. Next cycle fwd_a_e = 01 from W.
- x0 guard: E "lw x0", D reads x0 -> no stall. M writes x0 -> fwd 00.
- Branch with simultaneous lu: ex_branch_taken = 1 together with lu -> flush_d = flush_e = 1, stall_f = 0, flush_cnt = 1, stall_cnt unchanged.
- mem_wait held 3 cycles during a pending branch:
  - freeze = 1 with no flush for 3 cycles, slots unchanged, freeze_cnt = 3.
  - The flush fires on the first cycle after mem_wait drops.
- Counter saturation with CNT_W = 4: 20 lu cycles -> stall_cnt = 15. Then assert rst low mid-stall -> all outputs and counters 0 asynchronously.
